imem_loader: RTL

- Writer-side counterpart of the instruction memory. Receives a program image as a byte stream over a valid/ready handshake and writes 32-bit little-endian words into the instruction memory write port.
- Holds the core in reset until a complete image has loaded and its checksum matches.
- Sits between the boot/debug byte source (UART receiver or testbench) and the instruction memory plus the core reset input.

---
 rtl/imem_loader_pkg.sv | 8 +
 rtl/imem_word_assembler.sv | 46 ++++
 rtl/imem_loader.sv | 118 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR} ldr_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_assembler.sv
// Collects payload bytes into little-endian words and keeps the running XOR checksum.
module imem_word_assembler
  import imem_loader_pkg::*;
#(
  parameter int N_Bits = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        data,
  output logic              word_done,
  output logic [N_Bits-1:0] word,
  output logic [7:0]        chk
);

  logic [1:0]                       byte_cnt;
  logic [8*(BYTES_PER_WORD-1)-1:0] low_bytes;

  // The top byte is never stored: the completed word is formed from the byte
  // being accepted right now, so the write can be issued on the same edge.
  assign word_done = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign word      = N_Bits'({data, low_bytes});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      low_bytes <= '0;
      chk       <= '0;
    end else if (clear) begin
      byte_cnt  <= '0;
      low_bytes <= '0;
      chk       <= '0;
    end else if (accept) begin
      chk      <= chk ^ data;
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    low_bytes[7:0]   <= data;
        2'd1:    low_bytes[15:8]  <= data;
        2'd2:    low_bytes[23:16] <= data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory and
// releases the core from reset only after a verified load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int N_Bits = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [N_Bits-1:0] mem_addr,
  output logic [N_Bits-1:0] mem_wd,
  output logic              core_rst_n,
  output logic              done,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);

  ldr_state_t        state;
  logic [15:0]       len;
  logic [AW-1:0]     word_idx;
  logic              accept;
  logic              start_go;
  logic              asm_accept;
  logic              word_done;
  logic [N_Bits-1:0] word;
  logic [7:0]        chk;
  logic              last_word;

  assign accept     = in_valid && in_ready;
  assign start_go   = start && (state == IDLE || state == DONE || state == ERR);
  assign asm_accept = accept && (state == DATA);
  assign last_word  = (32'(word_idx) + 32'd1) == 32'(len);

  imem_word_assembler #(.N_Bits(N_Bits)) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_go),
    .accept    (asm_accept),
    .data      (in_data),
    .word_done (word_done),
    .word      (word),
    .chk       (chk)
  );

  // The final word's write is issued on the same edge that moves to CHK, so the
  // checksum byte can already be taken while that write is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len        <= '0;
      word_idx   <= '0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wd     <= '0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (start_go) begin
        state      <= LEN_LO;
        len        <= '0;
        word_idx   <= '0;
        in_ready   <= 1'b1;
        core_rst_n <= 1'b0;
        done       <= 1'b0;
        err        <= 1'b0;
      end else begin
        case (state)
          LEN_LO: if (accept) begin
            len[7:0] <= in_data;
            state    <= LEN_HI;
          end
          LEN_HI: if (accept) begin
            len[15:8] <= in_data;
            if ({in_data, len[7:0]} == 16'd0) begin
              state <= CHK;
            end else if ({in_data, len[7:0]} > 16'(DEPTH)) begin
              state    <= ERR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
          DATA: if (word_done) begin
            mem_we   <= 1'b1;
            mem_addr <= N_Bits'({word_idx, 2'b00});
            mem_wd   <= word;
            word_idx <= word_idx + 1'b1;
            if (last_word) state <= CHK;
          end
          CHK: if (accept) begin
            in_ready <= 1'b0;
            if (in_data == chk) begin
              state      <= DONE;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
